mem_access_ctrl: RTL and testbench

Load/store sequencer between the datapath's memory stage and a single-port, word-wide synchronous data memory. It accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time over a valid/ready handshake. It drives the memory port, performing read-modify-write for sub-word stores because the memory has no byte enables. It returns the extended load result, or an error, over a one-cycle response pulse.

---
 rtl/mem_access_if.sv | 31 +++
 rtl/mem_access_ctrl.sv | 127 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Request/response and memory-port bundle for the load/store sequencer.
// The slave modport is the controller's view; master is the datapath/memory side.
interface mem_access_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a word-wide single-port memory without byte enables.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module mem_access_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  mem_access_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_err;
  logic [31:0]       load_ext;
  logic [31:0]       merged;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;

  // Misaligned halves/words and the reserved size code never touch memory.
  assign req_err = (bus.req_op[1:0] == 2'b11) ||
                   (bus.req_op[1:0] == SZ_HALF && bus.req_addr[0]) ||
                   (bus.req_op[1:0] == SZ_WORD && bus.req_addr[1:0] != 2'b00);

  assign lane_b = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    load_ext = bus.mem_rdata;
    merged   = bus.mem_rdata;
    case (op_q[1:0])
      SZ_BYTE: begin
        load_ext = {{24{~op_q[2] & lane_b[7]}}, lane_b};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_ext = {{16{~op_q[2] & lane_h[15]}}, lane_h};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          err_d   = req_err;
          rdata_d = '0;
          if (req_err)
            state_d = RESP;
          else if (bus.req_op[3] && bus.req_op[1:0] == SZ_WORD)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD:   state_d = CAP;
      CAP: begin
        if (op_q[3]) begin
          merge_d = merged;
          state_d = WR;
        end else begin
          rdata_d = load_ext;
          state_d = RESP;
        end
      end
      WR:   state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Strobes are gated by reset so an in-flight write can never land in the reset cycle.
  assign bus.req_ready  = (state_q == IDLE) && !reset;
  assign bus.resp_valid = (state_q == RESP) && !reset;
  assign bus.mem_en     = (state_q == RD || state_q == WR) && !reset;
  assign bus.mem_we     = (state_q == WR) && !reset;
  assign bus.mem_addr   = addr_q[ADDR_W-1:2];
  assign bus.mem_wdata  = (op_q[1:0] == SZ_WORD) ? wdata_q : merge_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: vector table plus hand sequences, with response and
// write scoreboards checked against a behavioural memory on the falling edge.
module tb_mem_access_ctrl;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } resp_exp_t;

  typedef struct {
    int          cyc;
    logic [5:0]  idx;
    logic [31:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   en_cnt = 0;

  resp_exp_t   resp_q[$];
  wr_exp_t     wr_q[$];
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  vec_t        vecs [20];

  mem_access_if #(.ADDR_W(8)) bus();

  mem_access_ctrl #(.ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous single-port memory.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_en) en_cnt++;
    if (bus.resp_valid) begin
      if (resp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        resp_exp_t e;
        e = resp_q.pop_front();
        check("resp_cycle", cyc, e.cyc);
        check("resp_rdata", bus.resp_rdata, e.rdata);
        check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
      end
    end
    if (bus.mem_en && bus.mem_we) begin
      if (wr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write: got write to word %0d expected none (cycle %0d)",
                 bus.mem_addr, cyc);
      end else begin
        wr_exp_t w;
        w = wr_q.pop_front();
        check("write_cycle", cyc, w.cyc);
        check("write_addr", {26'd0, bus.mem_addr}, {26'd0, w.idx});
        check("write_data", bus.mem_wdata, w.data);
      end
    end
  end

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] size,
                                            input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    case (size)
      2'b00:   begin sh = 8 * a;         mask = 32'h0000_00FF << sh; end
      2'b01:   begin sh = 16 * int'(a[1]); mask = 32'h0000_FFFF << sh; end
      default: begin sh = 0;             mask = 32'hFFFF_FFFF;       end
    endcase
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic issue(input vec_t v);
    int budget = 0;
    while (!bus.req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.req_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 50 cycles");
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    resp_q.push_back('{cyc + v.lat, v.exp_rdata, v.exp_err});
    if (v.op[3] && !v.exp_err) begin
      ref_mem[v.addr[7:2]] = ref_store(ref_mem[v.addr[7:2]], v.op[1:0], v.addr[1:0], v.wdata);
      wr_q.push_back('{cyc + v.lat - 1, v.addr[7:2], ref_mem[v.addr[7:2]]});
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (resp_q.size() != 0 || wr_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d responses and %0d writes pending expected 0",
               resp_q.size(), wr_q.size());
      resp_q.delete();
      wr_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int en_before;
    int n;
    int ts [3];

    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

    //            op       addr   wdata         exp_rdata     err  lat
    vecs[0]  = '{4'b1010, 8'h04, 32'hDEADBEEF, 32'h00000000, 1'b0, 2};
    vecs[1]  = '{4'b0010, 8'h04, 32'h0,        32'hDEADBEEF, 1'b0, 3};
    vecs[2]  = '{4'b1000, 8'h05, 32'h123456A5, 32'h00000000, 1'b0, 4};
    vecs[3]  = '{4'b0000, 8'h05, 32'h0,        32'hFFFFFFA5, 1'b0, 3};
    vecs[4]  = '{4'b0100, 8'h05, 32'h0,        32'h000000A5, 1'b0, 3};
    vecs[5]  = '{4'b1001, 8'h06, 32'hABCD1234, 32'h00000000, 1'b0, 4};
    vecs[6]  = '{4'b0001, 8'h06, 32'h0,        32'h00001234, 1'b0, 3};
    vecs[7]  = '{4'b0101, 8'h04, 32'h0,        32'h0000A5EF, 1'b0, 3};
    vecs[8]  = '{4'b0001, 8'h04, 32'h0,        32'hFFFFA5EF, 1'b0, 3};
    vecs[9]  = '{4'b0100, 8'h07, 32'h0,        32'h00000012, 1'b0, 3};
    vecs[10] = '{4'b0110, 8'h04, 32'h0,        32'h1234A5EF, 1'b0, 3};
    vecs[11] = '{4'b0010, 8'h06, 32'h0,        32'h00000000, 1'b1, 1};
    vecs[12] = '{4'b1001, 8'h03, 32'h5555,     32'h00000000, 1'b1, 1};
    vecs[13] = '{4'b0011, 8'h00, 32'h0,        32'h00000000, 1'b1, 1};
    vecs[14] = '{4'b1010, 8'h08, 32'h11223344, 32'h00000000, 1'b0, 2};
    vecs[15] = '{4'b1000, 8'h0B, 32'hFFFFFF80, 32'h00000000, 1'b0, 4};
    vecs[16] = '{4'b0000, 8'h0B, 32'h0,        32'hFFFFFF80, 1'b0, 3};
    vecs[17] = '{4'b0001, 8'h0A, 32'h0,        32'hFFFF8022, 1'b0, 3};
    vecs[18] = '{4'b0100, 8'h08, 32'h0,        32'h00000044, 1'b0, 3};
    vecs[19] = '{4'b0000, 8'h06, 32'h0,        32'h00000034, 1'b0, 3};

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, bus.req_ready}, 32'd0);
    check("reset_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("reset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_reset_ready", {31'd0, bus.req_ready}, 32'd1);
    check("post_reset_rdata", bus.resp_rdata, 32'd0);
    check("post_reset_err", {31'd0, bus.resp_err}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      en_before = en_cnt;
      issue(vecs[i]);
      drain();
      if (vecs[i].exp_err) check("err_no_mem_access", en_cnt, en_before);
    end

    // Reset during the read phase of a byte store: nothing may be written or answered.
    bus.req_valid = 1'b1;
    bus.req_op    = 4'b1000;
    bus.req_addr  = 8'h05;
    bus.req_wdata = 32'h0000_0077;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst_seq_rd_en", {31'd0, bus.mem_en}, 32'd1);
    check("rst_seq_rd_we", {31'd0, bus.mem_we}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_seq_ready_low", {31'd0, bus.req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_seq_ready_after", {31'd0, bus.req_ready}, 32'd1);
    repeat (6) @(negedge clk);
    check("rst_seq_word_kept", mem[1], 32'h1234A5EF);
    issue('{4'b0010, 8'h04, 32'h0, 32'h1234A5EF, 1'b0, 3});
    drain();

    // req_valid held high across three loads: one acceptance per IDLE visit.
    bus.req_valid = 1'b1;
    bus.req_op    = 4'b0010;
    bus.req_addr  = 8'h08;
    n = 0;
    for (int i = 0; i < 30 && n < 3; i++) begin
      if (bus.req_ready) begin
        ts[n] = cyc;
        resp_q.push_back('{cyc + 3, 32'h80223344, 1'b0});
        n++;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check("held_accept_count", n, 3);
    if (n == 3) begin
      check("held_interval_1", ts[1] - ts[0], 4);
      check("held_interval_2", ts[2] - ts[1], 4);
    end
    drain();
    repeat (4) @(negedge clk);
    check("held_no_extra_resp", resp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
